// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the register writeback stage
package wb_pkg;

  typedef logic [3:0]  reg_idx_t;
  typedef logic [63:0] reg_val_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_DEST,
    WR_SPECIAL,
    WR_RSP
  } wb_state_t;

  localparam reg_idx_t RSP_IDX = 4'd4;

  typedef struct packed {
    logic     valid;
    reg_idx_t idx;
    reg_val_t val;
  } wb_write_t;

  typedef struct packed {
    wb_write_t dest;
    wb_write_t special;
    wb_write_t rsp;
  } wb_req_t;

  // First requested write state strictly after 'from' in the drain order
  // DEST -> SPECIAL -> RSP; IDLE as 'from' means "start of the instruction".
  function automatic wb_state_t nextWriteState(input wb_req_t r, input wb_state_t from);
    wb_state_t s;
    s = IDLE;
    if (from == IDLE && r.dest.valid) begin
      s = WR_DEST;
    end else if ((from == IDLE || from == WR_DEST) && r.special.valid) begin
      s = WR_SPECIAL;
    end else if (from != WR_RSP && r.rsp.valid) begin
      s = WR_RSP;
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_1w.sv
// rtl/regfile_1w.sv - 16x64 architectural register file, one write port, full read-out
module regfile_1w
  import wb_pkg::*;
#(
  parameter int       RSP_INDEX = 4,
  parameter reg_val_t RSP_RESET = '0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     writeEn,
  input  reg_idx_t writeIdx,
  input  reg_val_t writeVal,
  output reg_val_t regs [16]
);

  reg_val_t store [16];

  // Storage: RSP comes out of reset at its own value, everything else at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        store[i] <= (i == RSP_INDEX) ? RSP_RESET : '0;
      end
    end else if (writeEn) begin
      store[writeIdx] <= writeVal;
    end
  end

  assign regs = store;

endmodule

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - drains up to three register writes per retiring instruction
module register_writeback
  import wb_pkg::*;
#(
  parameter int       NUM_REGS  = 16,
  parameter int       DATA_W    = 64,
  parameter int       RSP_INDEX = 4,
  parameter reg_val_t RSP_RESET = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              canWriteIn,
  input  logic [3:0]        destRegIn,
  input  logic              destRegValidIn,
  input  logic [63:0]       destValIn,
  input  logic [3:0]        destRegisterSpecialIn,
  input  logic              destRegisterSpecialValidIn,
  input  logic [63:0]       destValSpecialIn,
  input  logic              rspUpdateValidIn,
  input  logic [63:0]       rspValIn,
  output logic [DATA_W-1:0] registerFileOut [NUM_REGS],
  output logic [NUM_REGS-1:0] pendingMaskOut,
  output logic              wbStallOut,
  output logic [63:0]       retireCountOut,
  output logic              writeBusyOut
);

  wb_state_t  state, nextState;
  wb_req_t    hold, incoming;
  logic [63:0] retireCount;
  logic       lastWrite, wbStall, accept, acceptNoWrite;
  logic       writeEn;
  reg_idx_t   writeIdx;
  reg_val_t   writeVal;
  logic [NUM_REGS-1:0] mask;

  // Pack the retiring instruction's three write requests
  always_comb begin
    incoming               = '0;
    incoming.dest.valid    = destRegValidIn;
    incoming.dest.idx      = destRegIn;
    incoming.dest.val      = destValIn;
    incoming.special.valid = destRegisterSpecialValidIn;
    incoming.special.idx   = destRegisterSpecialIn;
    incoming.special.val   = destValSpecialIn;
    incoming.rsp.valid     = rspUpdateValidIn;
    incoming.rsp.idx       = reg_idx_t'(RSP_INDEX);
    incoming.rsp.val       = rspValIn;
  end

  // The last write cycle frees the stage, so a new instruction can enter on the same edge
  assign lastWrite     = (state != IDLE) && (nextWriteState(hold, state) == IDLE);
  assign wbStall       = (state != IDLE) && !lastWrite;
  assign accept        = canWriteIn && !wbStall;
  assign acceptNoWrite = accept && (nextWriteState(incoming, IDLE) == IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: keep draining the held instruction, else start the newly accepted one
  always_comb begin
    nextState = IDLE;
    if (wbStall)     nextState = nextWriteState(hold, state);
    else if (accept) nextState = nextWriteState(incoming, IDLE);
  end

  // Outputs: write port selection and pending mask of current plus remaining writes
  always_comb begin
    writeEn  = 1'b0;
    writeIdx = '0;
    writeVal = '0;
    mask     = '0;
    unique case (state)
      WR_DEST:    begin writeEn = 1'b1; writeIdx = hold.dest.idx;    writeVal = hold.dest.val;    end
      WR_SPECIAL: begin writeEn = 1'b1; writeIdx = hold.special.idx; writeVal = hold.special.val; end
      WR_RSP:     begin writeEn = 1'b1; writeIdx = hold.rsp.idx;     writeVal = hold.rsp.val;     end
      default:    ;
    endcase
    if (state == WR_DEST) mask[hold.dest.idx] = 1'b1;
    if ((state == WR_DEST || state == WR_SPECIAL) && hold.special.valid) mask[hold.special.idx] = 1'b1;
    if (state != IDLE && hold.rsp.valid) mask[hold.rsp.idx] = 1'b1;
  end

  // Holding register captures the whole instruction on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      hold <= '0;
    else if (accept) hold <= incoming;
  end

  // Retire counter: one per finished instruction; an old finish and a no-write accept can coincide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retireCount <= '0;
    else        retireCount <= retireCount + {63'b0, lastWrite} + {63'b0, acceptNoWrite};
  end

  regfile_1w #(
    .RSP_INDEX (RSP_INDEX),
    .RSP_RESET (RSP_RESET)
  ) uRegfile (
    .clk      (clk),
    .reset    (reset),
    .writeEn  (writeEn),
    .writeIdx (writeIdx),
    .writeVal (writeVal),
    .regs     (registerFileOut)
  );

  assign pendingMaskOut = mask;
  assign wbStallOut     = wbStall;
  assign retireCountOut = retireCount;
  assign writeBusyOut   = (state != IDLE);

endmodule

// File: tb/tb_register_writeback.sv
// tb/tb_register_writeback.sv - randomized bench against a queue-based writeback model
module tb_register_writeback;

  localparam logic [63:0] RSP_RST = 64'h0000_7FFF_FFFF_F000;

  logic        clk;
  logic        reset;
  logic        canWriteIn;
  logic [3:0]  destRegIn;
  logic        destRegValidIn;
  logic [63:0] destValIn;
  logic [3:0]  destRegisterSpecialIn;
  logic        destRegisterSpecialValidIn;
  logic [63:0] destValSpecialIn;
  logic        rspUpdateValidIn;
  logic [63:0] rspValIn;
  logic [63:0] registerFileOut [16];
  logic [15:0] pendingMaskOut;
  logic        wbStallOut;
  logic [63:0] retireCountOut;
  logic        writeBusyOut;

  register_writeback #(
    .NUM_REGS  (16),
    .DATA_W    (64),
    .RSP_INDEX (4),
    .RSP_RESET (RSP_RST)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .canWriteIn                 (canWriteIn),
    .destRegIn                  (destRegIn),
    .destRegValidIn             (destRegValidIn),
    .destValIn                  (destValIn),
    .destRegisterSpecialIn      (destRegisterSpecialIn),
    .destRegisterSpecialValidIn (destRegisterSpecialValidIn),
    .destValSpecialIn           (destValSpecialIn),
    .rspUpdateValidIn           (rspUpdateValidIn),
    .rspValIn                   (rspValIn),
    .registerFileOut            (registerFileOut),
    .pendingMaskOut             (pendingMaskOut),
    .wbStallOut                 (wbStallOut),
    .retireCountOut             (retireCountOut),
    .writeBusyOut               (writeBusyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outstanding writes as an ordered queue, plus plain register array
  typedef struct {
    logic [3:0]  idx;
    logic [63:0] val;
    bit          last;
  } pw_t;

  pw_t         pq [$];
  logic [63:0] mRegs [16];
  logic [63:0] mRetire;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    pq.delete();
    for (int i = 0; i < 16; i++) mRegs[i] = 64'h0;
    mRegs[4] = RSP_RST;
    mRetire  = 64'h0;
  endtask

  task automatic compareAll(input string phase);
    logic [15:0] m;
    m = 16'h0;
    foreach (pq[i]) m[pq[i].idx] = 1'b1;
    checkValue({phase, " mask"},   64'(pendingMaskOut), 64'(m));
    checkValue({phase, " stall"},  64'(wbStallOut),     64'(pq.size() > 1));
    checkValue({phase, " busy"},   64'(writeBusyOut),   64'(pq.size() > 0));
    checkValue({phase, " retire"}, retireCountOut,      mRetire);
    for (int i = 0; i < 16; i++) begin
      checkValue($sformatf("%s reg%0d", phase, i), registerFileOut[i], mRegs[i]);
    end
  endtask

  task automatic pushInstr();
    int nw;
    int k;
    nw = int'(destRegValidIn) + int'(destRegisterSpecialValidIn) + int'(rspUpdateValidIn);
    k = 0;
    if (nw == 0) mRetire = mRetire + 64'd1;
    if (destRegValidIn) begin
      k++;
      pq.push_back('{idx: destRegIn, val: destValIn, last: (k == nw)});
    end
    if (destRegisterSpecialValidIn) begin
      k++;
      pq.push_back('{idx: destRegisterSpecialIn, val: destValSpecialIn, last: (k == nw)});
    end
    if (rspUpdateValidIn) begin
      k++;
      pq.push_back('{idx: 4'd4, val: rspValIn, last: (k == nw)});
    end
  endtask

  // One clock: model retires the oldest outstanding write, then takes the new instruction
  task automatic step(input string phase);
    bit acc;
    pw_t e;
    acc = canWriteIn && !(pq.size() > 1);
    @(posedge clk);
    if (pq.size() > 0) begin
      e = pq.pop_front();
      mRegs[e.idx] = e.val;
      if (e.last) mRetire = mRetire + 64'd1;
    end
    if (acc) pushInstr();
    @(negedge clk);
    compareAll(phase);
  endtask

  task automatic setInstr(input logic cw,
                          input logic [3:0] d, input logic dv, input logic [63:0] dval,
                          input logic [3:0] s, input logic sv, input logic [63:0] sval,
                          input logic rv, input logic [63:0] rval);
    canWriteIn                 = cw;
    destRegIn                  = d;
    destRegValidIn             = dv;
    destValIn                  = dval;
    destRegisterSpecialIn      = s;
    destRegisterSpecialValidIn = sv;
    destValSpecialIn           = sval;
    rspUpdateValidIn           = rv;
    rspValIn                   = rval;
  endtask

  task automatic setIdle();
    setInstr(1'b0, 4'd0, 1'b0, 64'h0, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  function automatic logic [3:0] randIdx();
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 5));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    reset = 1'b0;
    setIdle();
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compareAll("reset");
    reset = 1'b1;
    @(negedge clk);
    compareAll("release");

    // Single write to R3
    setInstr(1'b1, 4'd3, 1'b1, 64'hDEAD_BEEF, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
    step("r3 accept");
    checkValue("r3 mask after accept", 64'(pendingMaskOut), 64'h0008);
    setIdle();
    step("r3 write");
    checkValue("r3 value", registerFileOut[3], 64'hDEAD_BEEF);
    checkValue("r3 retire", retireCountOut, 64'd1);

    // IMUL-style triple write, next instruction accepted on the last write edge
    setInstr(1'b1, 4'd0, 1'b1, 64'd5, 4'd2, 1'b1, 64'd7, 1'b1, 64'h1000);
    step("imul accept");
    checkValue("imul mask0", 64'(pendingMaskOut), 64'h0015);
    setIdle();
    step("imul w1");
    checkValue("imul mask1", 64'(pendingMaskOut), 64'h0014);
    step("imul w2");
    checkValue("imul mask2", 64'(pendingMaskOut), 64'h0010);
    checkValue("imul stall at last", 64'(wbStallOut), 64'h0);
    setInstr(1'b1, 4'd7, 1'b1, 64'h77, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
    step("imul w3");
    checkValue("imul mask3", 64'(pendingMaskOut), 64'h0080);
    checkValue("imul r4", registerFileOut[4], 64'h1000);
    setIdle();
    step("imul drain");

    // Back-to-back single writes R1, R1, R5
    setInstr(1'b1, 4'd1, 1'b1, 64'd1, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
    step("b2b 1");
    checkValue("b2b mask1", 64'(pendingMaskOut), 64'h0002);
    setInstr(1'b1, 4'd1, 1'b1, 64'd2, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
    step("b2b 2");
    checkValue("b2b mask2", 64'(pendingMaskOut), 64'h0002);
    setInstr(1'b1, 4'd5, 1'b1, 64'd3, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
    step("b2b 3");
    checkValue("b2b mask3", 64'(pendingMaskOut), 64'h0020);
    setIdle();
    step("b2b 4");
    checkValue("b2b r1", registerFileOut[1], 64'd2);
    checkValue("b2b r5", registerFileOut[5], 64'd3);

    // Duplicate index: dest R4 then RSP update
    setInstr(1'b1, 4'd4, 1'b1, 64'd9, 4'd0, 1'b0, 64'h0, 1'b1, 64'h2000);
    step("dup accept");
    setIdle();
    step("dup w1");
    checkValue("dup mask held", 64'(pendingMaskOut), 64'h0010);
    step("dup w2");
    checkValue("dup rsp", registerFileOut[4], 64'h2000);
    checkValue("dup mask clear", 64'(pendingMaskOut), 64'h0);

    // Randomized traffic; a stalled instruction is held unchanged by upstream
    for (int c = 0; c < 400; c++) begin
      if (!(canWriteIn && pq.size() > 1)) begin
        setInstr(1'($urandom_range(0, 9) < 7),
                 randIdx(), 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                 randIdx(), 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                 1'($urandom_range(0, 2) == 0), {$urandom(), $urandom()});
      end
      step("rand");
    end
    setIdle();
    repeat (3) step("rand drain");

    // Reset while the special write of an IMUL is pending
    setInstr(1'b1, 4'd8, 1'b1, 64'hAA, 4'd9, 1'b1, 64'hBB, 1'b1, 64'hCC);
    step("mid accept");
    setIdle();
    step("mid w1");
    checkValue("mid in special", 64'(wbStallOut), 64'h1);
    reset = 1'b0;
    #1;
    modelReset();
    compareAll("mid reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step("post reset");
    checkValue("post reset r9", registerFileOut[9], 64'h0);
    checkValue("post reset rsp", registerFileOut[4], RSP_RST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
- Write-side counterpart of the register-read stage. It owns the 16 x 64-bit architectural register file and drives it to the read stage as registerFileOut.
- Accepts one retiring instruction at a time from execute/memory. That instruction carries up to three register writes: primary destination, special destination (IMUL high half, RDX), and RSP update (push/pop/RETQ).
- Drains those writes through a single write port, one per cycle.
- Exposes a pending-write mask and wbStallOut so the read stage can block on hazards and back-pressure.

Parameters:
- NUM_REGS, 16, architectural register count; index width is 4.
- DATA_W, 64, register width.
- RSP_INDEX, 4, register index of RSP.
- RSP_RESET, 64'h0, reset value of RSP. All other registers reset to 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- canWriteIn  in  1  retiring instruction valid this cycle.
- destRegIn  in  4  primary destination index.
- destRegValidIn  in  1  primary write requested.
- destValIn  in  64  primary write data.
- destRegisterSpecialIn  in  4  special destination index.
- destRegisterSpecialValidIn  in  1  special write requested.
- destValSpecialIn  in  64  special write data.
- rspUpdateValidIn  in  1  RSP write requested.
- rspValIn  in  64  new RSP value.
- registerFileOut  out  16x64  current register contents (unpacked array [16] of [63:0]).
- pendingMaskOut  out  16  bit i = accepted but not yet written to register i.
- wbStallOut  out  1  upstream must hold; instruction not accepted.
- retireCountOut  out  64  instructions retired since reset.
- writeBusyOut  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - registerFileOut = 0, except RSP = RSP_RESET.
  - pendingMaskOut = 0, wbStallOut = 0, retireCountOut = 0, writeBusyOut = 0, FSM = IDLE.
  - Reset mid-drain discards all held writes and clears the mask.
- Accept:
  - Occurs on a rising edge when canWriteIn && !wbStallOut.
  - All write fields are latched into a holding register.
  - Each requested write gets a pending flag.
  - pendingMaskOut bits for the requested indices are set at that edge.
- FSM states: IDLE, WR_DEST, WR_SPECIAL, WR_RSP.
  - On accept, jump to the first requested state in the fixed order DEST -> SPECIAL -> RSP.
  - Each state performs its write on the next edge, then moves to the next requested state, or to IDLE if none remain.
  - An accept with no writes requested: stays IDLE, increments retireCountOut, no register change.
- Latency:
  - A write accepted at edge N is visible on registerFileOut after edge N+k, where k is its position (1..3) in the drain order.
  - The corresponding pendingMaskOut bit clears at the same edge the register is written.
- wbStallOut:
  - Combinational.
  - Equals 1 when the FSM is in a write state that is not the last requested write.
  - On the last write cycle it is 0, so a new instruction may be accepted at the same edge. Single-write instructions therefore sustain 1 per cycle.
- Same-edge accept and last write:
  - The old write completes first.
  - The new instruction's mask bits are OR-ed in after the old bit is cleared.
  - A bit for the same register as the old write stays set.
- Duplicate indices within one instruction:
  - Writes occur in order, so the later one wins (RSP overrides special overrides dest).
  - The mask bit clears only after the last write to that index.
- retireCountOut:
  - Increments by 1 on the edge performing an instruction's final write, or on the accept edge for no-write instructions.
  - Wraps modulo 2^64.
- canWriteIn while wbStallOut = 1: ignored; inputs must be held by upstream.

Decomposition:
- Shared package wb_pkg:
  - reg_idx_t (logic [3:0]).
  - reg_val_t (logic [63:0]).
  - wb_state_t enum {IDLE, WR_DEST, WR_SPECIAL, WR_RSP}.
  - RSP_IDX = 4'd4.
  - struct wb_req_t bundling the three {valid, index, value} triples.
- One natural sub-module, regfile_1w: 16x64 storage, one write port, full parallel read-out, async active-low reset with an RSP reset-value parameter.
- FSM, holding register, mask and counter stay in register_writeback.

Test Plan:
- Reset release, no activity -> all registers 0, RSP = RSP_RESET, pendingMaskOut = 0, retireCountOut = 0.
- Accept dest = R3, value 64'hDEAD_BEEF at edge N -> pendingMaskOut = 16'h0008 after N; R3 = DEADBEEF and mask = 0 after N+1; wbStallOut never 1; retireCountOut = 1.
- IMUL: dest R0 = 5, special R2 = 7, plus RSP = 64'h1000 -> wbStallOut = 1 for 2 cycles; writes land at N+1, N+2, N+3 in order R0, R2, R4; mask 16'h0015 -> 0014 -> 0010 -> 0000; a second instruction is accepted at edge N+3.
- Back-to-back single writes to R1 (=1), R1 (=2), R5 (=3) on consecutive cycles -> one accept per cycle; final R1 = 2, R5 = 3; R1 mask bit continuously set until the edge after the second R1 write.
- Duplicate: dest = R4 value 9 with RSP update 64'h2000 -> RSP ends 64'h2000; bit 4 clears only after the second write.
- Assert reset during WR_SPECIAL of an IMUL -> immediate clear of all outputs to reset values; no further writes after reset release.
